// File: rtl/sdram_sched_pkg.sv
// -----------------------------------------------------------------------------
// sdram_sched_pkg
// Shared definitions for the SDRAM block scheduler:
//   - sched_state_t : scheduler FSM encoding (IDLE, ISSUE, WAIT_DONE, REFRESH)
//   - CMD_WRITE / CMD_READ : polarity of cmd_write
//   - GNT_RD / GNT_WR : bit positions of the requesters in req/grant vectors
//   - rr_pick() : 2-way round-robin selection used by the arbiter
// -----------------------------------------------------------------------------
package sdram_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_REFRESH   = 2'd3
   } sched_state_t;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

   localparam int GNT_RD = 0;
   localparam int GNT_WR = 1;

   // A lone requester always wins; on a tie the side that did not win last time
   // is chosen. last_write=1 means the previous grant went to the write path.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_write);
      logic [1:0] pick;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last_write ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/sdram_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// sdram_sched_rr_arb
// Two-requester round-robin arbiter for the SDRAM block scheduler.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   req    in   [1:0] request vector, bit GNT_WR = write path, bit GNT_RD = read path
//   grant  out  [1:0] one-hot grant (combinational, same cycle as req)
// The remembered last winner resets to "read" so the first tie goes to write.
// -----------------------------------------------------------------------------
module sdram_sched_rr_arb
   import sdram_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic       last_write_r;
   logic [1:0] grant_s;

   // Grant selection from the current requests and the previous winner.
   always_comb begin
      grant_s = rr_pick(req, last_write_r);
   end

   assign grant = grant_s;

   // Remember which side won the most recent grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_write_r <= CMD_READ;
      end else if (grant_s != 2'b00) begin
         last_write_r <= grant_s[GNT_WR];
      end else begin
         last_write_r <= last_write_r;
      end
   end

endmodule

// File: rtl/sdram_block_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_block_scheduler
// Sequences block commands on the single SDRAM controller port. A write path
// drains the pipe-in FIFO into SDRAM, a read path fills the pipe-out FIFO from
// SDRAM; SDRAM is used as a circular buffer of 2**ADDR_WIDTH blocks.
//
// Optional feature: define SDRAM_REFRESH_EN to let this block schedule periodic
// refreshes (REFRESH_INTV cycles apart); otherwise refresh_req is tied low and
// refresh_ack is ignored.
//
// Ports:
//   sdram_clk, sdram_rst        clock, asynchronous active-high reset
//   wr_enable, rd_enable        path permits
//   in_fifo_count               words waiting in pipe-in FIFO
//   out_fifo_free               free words in pipe-out FIFO
//   cmd_valid/cmd_write/cmd_addr  block command to controller, held until cmd_ack
//   cmd_ack, cmd_done           controller accept / block complete pulses
//   refresh_req, refresh_ack    refresh handshake
//   used_blocks, full, empty    circular-buffer occupancy
//   busy                        FSM not in IDLE
// -----------------------------------------------------------------------------
module sdram_block_scheduler
   import sdram_sched_pkg::*;
#(
   parameter int BLOCK_WORDS  = 4,
   parameter int ADDR_WIDTH   = 20,
   parameter int FIFO_CNT_W   = 16,
   parameter int REFRESH_INTV = 780
)(
   input  logic                  sdram_clk,
   input  logic                  sdram_rst,
   input  logic                  wr_enable,
   input  logic                  rd_enable,
   input  logic [FIFO_CNT_W-1:0] in_fifo_count,
   input  logic [FIFO_CNT_W-1:0] out_fifo_free,
   output logic                  cmd_valid,
   output logic                  cmd_write,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_ack,
   input  logic                  cmd_done,
   output logic                  refresh_req,
   input  logic                  refresh_ack,
   output logic [ADDR_WIDTH:0]   used_blocks,
   output logic                  full,
   output logic                  empty,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH:0]   CAPACITY_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   ONE_USED_C  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ONE_PTR_C   = ADDR_WIDTH'(1);
   localparam logic [FIFO_CNT_W-1:0] BLK_WORDS_C = FIFO_CNT_W'(BLOCK_WORDS);

   sched_state_t          state_r;
   sched_state_t          state_nx_s;
   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [ADDR_WIDTH:0]   used_r;
   logic [ADDR_WIDTH:0]   used_nx_s;
   logic                  cmd_valid_r;
   logic                  cmd_valid_nx_s;
   logic                  cmd_write_r;
   logic                  cmd_write_nx_s;
   logic [ADDR_WIDTH-1:0] cmd_addr_r;
   logic [ADDR_WIDTH-1:0] cmd_addr_nx_s;
   logic                  full_r;
   logic                  empty_r;
   logic                  busy_r;
   logic                  refresh_req_r;
   logic                  w_ok_s;
   logic                  r_ok_s;
   logic [1:0]            req_s;
   logic [1:0]            grant_s;
   logic                  done_upd_s;
   logic                  refresh_pending_s;
   logic                  refresh_clr_s;

   // Eligibility; requests reach the arbiter only in IDLE with no refresh owed,
   // so the round-robin history advances only on real grants.
   always_comb begin
      w_ok_s = wr_enable & (in_fifo_count >= BLK_WORDS_C) & ~full_r;
      r_ok_s = rd_enable & (out_fifo_free >= BLK_WORDS_C) & ~empty_r;
      if ((state_r == ST_IDLE) && !refresh_pending_s) begin
         req_s = {w_ok_s, r_ok_s};
      end else begin
         req_s = 2'b00;
      end
   end

   sdram_sched_rr_arb u_arb (
      .clk   (sdram_clk),
      .rst   (sdram_rst),
      .req   (req_s),
      .grant (grant_s)
   );

`ifdef SDRAM_REFRESH_EN
   localparam int                RCNT_W        = (REFRESH_INTV > 1) ? $clog2(REFRESH_INTV) : 1;
   localparam logic [RCNT_W-1:0] RCNT_RELOAD_C = RCNT_W'(REFRESH_INTV - 1);

   logic [RCNT_W-1:0] refresh_cnt_r;
   logic              refresh_pending_r;

   // Refresh interval timer; an expiry outranks a same-cycle clear so no
   // refresh is ever lost.
   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         refresh_cnt_r     <= RCNT_RELOAD_C;
         refresh_pending_r <= 1'b0;
      end else if (refresh_cnt_r == {RCNT_W{1'b0}}) begin
         refresh_cnt_r     <= RCNT_RELOAD_C;
         refresh_pending_r <= 1'b1;
      end else begin
         refresh_cnt_r     <= refresh_cnt_r - RCNT_W'(1);
         refresh_pending_r <= refresh_clr_s ? 1'b0 : refresh_pending_r;
      end
   end

   assign refresh_pending_s = refresh_pending_r;
`else
   logic unused_refresh_s;

   assign refresh_pending_s = 1'b0;
   assign unused_refresh_s  = refresh_ack ^ refresh_clr_s ^ (REFRESH_INTV == 0);
`endif

   // FSM next state and next command outputs; the command is latched on grant
   // and held untouched until the controller acknowledges it.
   always_comb begin
      state_nx_s     = state_r;
      cmd_valid_nx_s = cmd_valid_r;
      cmd_write_nx_s = cmd_write_r;
      cmd_addr_nx_s  = cmd_addr_r;
      done_upd_s     = 1'b0;
      refresh_clr_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (refresh_pending_s) begin
               state_nx_s = ST_REFRESH;
            end else if (grant_s[GNT_WR]) begin
               state_nx_s     = ST_ISSUE;
               cmd_valid_nx_s = 1'b1;
               cmd_write_nx_s = CMD_WRITE;
               cmd_addr_nx_s  = wr_ptr_r;
            end else if (grant_s[GNT_RD]) begin
               state_nx_s     = ST_ISSUE;
               cmd_valid_nx_s = 1'b1;
               cmd_write_nx_s = CMD_READ;
               cmd_addr_nx_s  = rd_ptr_r;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (cmd_ack) begin
               cmd_valid_nx_s = 1'b0;
               if (cmd_done) begin
                  state_nx_s = ST_IDLE;
                  done_upd_s = 1'b1;
               end else begin
                  state_nx_s = ST_WAIT_DONE;
               end
            end else begin
               state_nx_s = ST_ISSUE;
            end
         end
         ST_WAIT_DONE: begin
            if (cmd_done) begin
               state_nx_s = ST_IDLE;
               done_upd_s = 1'b1;
            end else begin
               state_nx_s = ST_WAIT_DONE;
            end
         end
         ST_REFRESH: begin
`ifdef SDRAM_REFRESH_EN
            if (refresh_ack) begin
               state_nx_s    = ST_IDLE;
               refresh_clr_s = 1'b1;
            end else begin
               state_nx_s = ST_REFRESH;
            end
`else
            state_nx_s = ST_IDLE;
`endif
         end
         default: begin
            state_nx_s     = ST_IDLE;
            cmd_valid_nx_s = 1'b0;
         end
      endcase
   end

   // Occupancy after a completed block; saturating guards keep the counter
   // in range even if eligibility were ever bypassed.
   always_comb begin
      used_nx_s = used_r;
      if (done_upd_s) begin
         if (cmd_write_r == CMD_WRITE) begin
            used_nx_s = full_r ? used_r : (used_r + ONE_USED_C);
         end else begin
            used_nx_s = empty_r ? used_r : (used_r - ONE_USED_C);
         end
      end else begin
         used_nx_s = used_r;
      end
   end

   // FSM state and registered command / status outputs.
   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         state_r       <= ST_IDLE;
         cmd_valid_r   <= 1'b0;
         cmd_write_r   <= 1'b0;
         cmd_addr_r    <= {ADDR_WIDTH{1'b0}};
         busy_r        <= 1'b0;
         refresh_req_r <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         cmd_valid_r   <= cmd_valid_nx_s;
         cmd_write_r   <= cmd_write_nx_s;
         cmd_addr_r    <= cmd_addr_nx_s;
         busy_r        <= (state_nx_s != ST_IDLE);
         refresh_req_r <= (state_nx_s == ST_REFRESH);
      end
   end

   // Circular-buffer pointers and occupancy, moved only by a completed block.
   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         wr_ptr_r <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r <= {ADDR_WIDTH{1'b0}};
         used_r   <= {(ADDR_WIDTH+1){1'b0}};
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (done_upd_s && (cmd_write_r == CMD_WRITE)) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR_C;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (done_upd_s && (cmd_write_r == CMD_READ)) begin
            rd_ptr_r <= rd_ptr_r + ONE_PTR_C;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         used_r  <= used_nx_s;
         full_r  <= (used_nx_s == CAPACITY_C);
         empty_r <= (used_nx_s == {(ADDR_WIDTH+1){1'b0}});
      end
   end

   assign cmd_valid   = cmd_valid_r;
   assign cmd_write   = cmd_write_r;
   assign cmd_addr    = cmd_addr_r;
   assign refresh_req = refresh_req_r;
   assign used_blocks = used_r;
   assign full        = full_r;
   assign empty       = empty_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_sdram_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sdram_block_scheduler
// Directed bench for sdram_block_scheduler with ADDR_WIDTH=3, BLOCK_WORDS=4.
// A controller model acks 2 cycles after cmd_valid and signals done 4 cycles
// later (or together with the ack in same-cycle mode) and logs each command.
// Define SDRAM_REFRESH_EN to exercise the refresh scheduling.
// -----------------------------------------------------------------------------
module tb_sdram_block_scheduler;

   localparam int AW = 3;
   localparam int BW = 4;
   localparam int FW = 16;
   localparam int RI = 50;

   logic          sdram_clk;
   logic          sdram_rst;
   logic          wr_enable;
   logic          rd_enable;
   logic [FW-1:0] in_fifo_count;
   logic [FW-1:0] out_fifo_free;
   logic          cmd_valid;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic          cmd_ack;
   logic          cmd_done;
   logic          refresh_req;
   logic          refresh_ack;
   logic [AW:0]   used_blocks;
   logic          full;
   logic          empty;
   logic          busy;

   int          n_checks;
   int          n_fail;
   logic [AW:0] log_q[$];   // {cmd_write, cmd_addr} per issued command
   bit          bfm_en;
   bit          bfm_same;

   sdram_block_scheduler #(
      .BLOCK_WORDS  (BW),
      .ADDR_WIDTH   (AW),
      .FIFO_CNT_W   (FW),
      .REFRESH_INTV (RI)
   ) dut (
      .sdram_clk     (sdram_clk),
      .sdram_rst     (sdram_rst),
      .wr_enable     (wr_enable),
      .rd_enable     (rd_enable),
      .in_fifo_count (in_fifo_count),
      .out_fifo_free (out_fifo_free),
      .cmd_valid     (cmd_valid),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_ack       (cmd_ack),
      .cmd_done      (cmd_done),
      .refresh_req   (refresh_req),
      .refresh_ack   (refresh_ack),
      .used_blocks   (used_blocks),
      .full          (full),
      .empty         (empty),
      .busy          (busy)
   );

   initial sdram_clk = 1'b0;
   always #5 sdram_clk = ~sdram_clk;

   task automatic bfm();
      forever begin
         @(negedge sdram_clk);
         if (bfm_en && cmd_valid && !sdram_rst) begin
            log_q.push_back({cmd_write, cmd_addr});
            @(negedge sdram_clk);
            cmd_ack = 1'b1;
            if (bfm_same) cmd_done = 1'b1;
            @(negedge sdram_clk);
            cmd_ack  = 1'b0;
            cmd_done = 1'b0;
            if (!bfm_same) begin
               repeat (3) @(negedge sdram_clk);
               cmd_done = 1'b1;
               @(negedge sdram_clk);
               cmd_done = 1'b0;
            end
         end
      end
   endtask

   task automatic wait_log(input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge sdram_clk);
         if (log_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      int run;
      run = 0;
      ok  = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge sdram_clk);
         if (!busy && !cmd_valid) run++;
         else run = 0;
         if (run >= 3) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      sdram_rst = 1'b1;
      repeat (5) @(negedge sdram_clk);
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %0b want 0", cmd_valid); end
      n_checks++; if (used_blocks !== 4'd0) begin n_fail++; $display("FAIL reset_used got %0d want 0", used_blocks); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_checks++; if ({cmd_write, cmd_addr} !== 4'd0) begin n_fail++; $display("FAIL reset_cmd got %0h want 0", {cmd_write, cmd_addr}); end
      n_checks++; if (refresh_req !== 1'b0) begin n_fail++; $display("FAIL reset_refresh_req got %0b want 0", refresh_req); end
      sdram_rst = 1'b0;
      repeat (5) @(negedge sdram_clk);
      n_checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle busy=%0b valid=%0b want 0/0", busy, cmd_valid); end
      n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL post_reset_cmds got %0d want 0", log_q.size()); end
   endtask

   task automatic test_write_fill();
      bit ok;
      logic [AW:0] got;
      log_q.delete();
      in_fifo_count = 16'd32;
      out_fifo_free = 16'd0;
      bfm_en    = 1'b1;
      wr_enable = 1'b1;
      wait_log(8, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_timeout got %0d cmds want 8", log_q.size()); end
      wait_idle(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_idle_timeout busy=%0b want 0", busy); end
      repeat (30) @(negedge sdram_clk);
      n_checks++; if (log_q.size() != 8) begin n_fail++; $display("FAIL fill_count got %0d want 8", log_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < log_q.size()) ? log_q[i] : 4'hx;
         n_checks++; if (got !== {1'b1, AW'(i)}) begin n_fail++; $display("FAIL fill_cmd%0d got %0h want %0h", i, got, {1'b1, AW'(i)}); end
      end
      n_checks++; if (full !== 1'b1 || used_blocks !== 4'd8 || empty !== 1'b0) begin n_fail++; $display("FAIL fill_status full=%0b used=%0d empty=%0b want 1/8/0", full, used_blocks, empty); end
      wr_enable = 1'b0;
   endtask

   task automatic test_read_drain();
      bit ok;
      logic [AW:0] got;
      log_q.delete();
      out_fifo_free = 16'd64;
      rd_enable     = 1'b1;
      wait_log(8, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL drain_timeout got %0d cmds want 8", log_q.size()); end
      wait_idle(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL drain_idle_timeout busy=%0b want 0", busy); end
      repeat (30) @(negedge sdram_clk);
      n_checks++; if (log_q.size() != 8) begin n_fail++; $display("FAIL drain_count got %0d want 8", log_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < log_q.size()) ? log_q[i] : 4'hx;
         n_checks++; if (got !== {1'b0, AW'(i)}) begin n_fail++; $display("FAIL drain_cmd%0d got %0h want %0h", i, got, {1'b0, AW'(i)}); end
      end
      n_checks++; if (empty !== 1'b1 || used_blocks !== 4'd0 || full !== 1'b0) begin n_fail++; $display("FAIL drain_status empty=%0b used=%0d full=%0b want 1/0/0", empty, used_blocks, full); end
      rd_enable = 1'b0;
   endtask

   task automatic test_alternate();
      bit ok;
      logic [AW:0] got;
      logic [AW:0] exp;
      int umin;
      int umax;
      // Five writes (addr 0..4) then one read (addr 0): used=4, last winner=read.
      log_q.delete();
      wr_enable = 1'b1;
      wait_log(5, 300, ok);
      wr_enable = 1'b0;
      wait_idle(100, ok);
      rd_enable = 1'b1;
      wait_log(6, 100, ok);
      rd_enable = 1'b0;
      wait_idle(100, ok);
      n_checks++; if (used_blocks !== 4'd4) begin n_fail++; $display("FAIL alt_setup_used got %0d want 4", used_blocks); end
      log_q.delete();
      umin = 99;
      umax = -1;
      wr_enable = 1'b1;
      rd_enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge sdram_clk);
         if (int'(used_blocks) < umin) umin = int'(used_blocks);
         if (int'(used_blocks) > umax) umax = int'(used_blocks);
         if (log_q.size() >= 10) begin
            ok = 1'b1;
            break;
         end
      end
      wr_enable = 1'b0;
      rd_enable = 1'b0;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL alt_timeout got %0d cmds want 10", log_q.size()); end
      wait_idle(100, ok);
      n_checks++; if (log_q.size() != 10) begin n_fail++; $display("FAIL alt_count got %0d want 10", log_q.size()); end
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) exp = {1'b1, AW'((5 + i / 2) % 8)};
         else            exp = {1'b0, AW'((1 + i / 2) % 8)};
         got = (i < log_q.size()) ? log_q[i] : 4'hx;
         n_checks++; if (got !== exp) begin n_fail++; $display("FAIL alt_cmd%0d got %0h want %0h", i, got, exp); end
      end
      n_checks++; if (umin < 3 || umax > 5) begin n_fail++; $display("FAIL alt_used_range got %0d..%0d want within 3..5", umin, umax); end
      n_checks++; if (used_blocks !== 4'd4) begin n_fail++; $display("FAIL alt_final_used got %0d want 4", used_blocks); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bfm_en = 1'b0;
      log_q.delete();
      wr_enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sdram_clk);
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
      end
      wr_enable = 1'b0;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_grant_timeout valid=%0b want 1", cmd_valid); end
      n_checks++; if ({cmd_write, cmd_addr} !== 4'hA) begin n_fail++; $display("FAIL mid_cmd got %0h want a", {cmd_write, cmd_addr}); end
      @(negedge sdram_clk);
      n_checks++; if (cmd_valid !== 1'b1 || {cmd_write, cmd_addr} !== 4'hA) begin n_fail++; $display("FAIL mid_hold valid=%0b cmd=%0h want 1/a", cmd_valid, {cmd_write, cmd_addr}); end
      cmd_ack = 1'b1;
      @(negedge sdram_clk);
      cmd_ack = 1'b0;
      n_checks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wait_done busy=%0b valid=%0b want 1/0", busy, cmd_valid); end
      sdram_rst = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0 || used_blocks !== 4'd0) begin n_fail++; $display("FAIL mid_async_reset busy=%0b used=%0d want 0/0", busy, used_blocks); end
      repeat (2) @(negedge sdram_clk);
      sdram_rst = 1'b0;
      @(negedge sdram_clk);
      cmd_done = 1'b1;
      @(negedge sdram_clk);
      cmd_done = 1'b0;
      @(negedge sdram_clk);
      n_checks++; if (used_blocks !== 4'd0 || empty !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stray_done used=%0d empty=%0b busy=%0b valid=%0b want 0/1/0/0", used_blocks, empty, busy, cmd_valid); end
      bfm_en = 1'b1;
      wr_enable = 1'b1;
      wait_log(1, 50, ok);
      wr_enable = 1'b0;
      wait_idle(100, ok);
      n_checks++; if (log_q.size() != 1 || log_q[0] !== 4'h8) begin n_fail++; $display("FAIL mid_restart cmds=%0d first=%0h want 1/8", log_q.size(), (log_q.size() > 0) ? log_q[0] : 4'hx); end
      n_checks++; if (used_blocks !== 4'd1) begin n_fail++; $display("FAIL mid_restart_used got %0d want 1", used_blocks); end
   endtask

   task automatic test_ack_done_same_cycle();
      bit ok;
      log_q.delete();
      bfm_same  = 1'b1;
      wr_enable = 1'b1;
      wait_log(1, 50, ok);
      wr_enable = 1'b0;
      wait_idle(100, ok);
      bfm_same = 1'b0;
      n_checks++; if (log_q.size() != 1 || log_q[0] !== 4'h9) begin n_fail++; $display("FAIL same_cmd cmds=%0d first=%0h want 1/9", log_q.size(), (log_q.size() > 0) ? log_q[0] : 4'hx); end
      n_checks++; if (used_blocks !== 4'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL same_used used=%0d busy=%0b want 2/0", used_blocks, busy); end
   endtask

`ifdef SDRAM_REFRESH_EN
   task automatic test_refresh();
      bit ok;
      int cyc;
      int n0;
      sdram_rst = 1'b1;
      repeat (2) @(negedge sdram_clk);
      sdram_rst = 1'b0;
      log_q.delete();
      wr_enable = 1'b1;
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sdram_clk);
         cyc++;
         if (refresh_req) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++; if (!ok) begin n_fail++; $display("FAIL refresh_timeout refresh_req=%0b want 1", refresh_req); end
      n_checks++; if (cyc < 51 || cyc > 64) begin n_fail++; $display("FAIL refresh_cycle got %0d want 51..64", cyc); end
      n_checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL refresh_excl valid=%0b busy=%0b want 0/1", cmd_valid, busy); end
      n0 = log_q.size();
      repeat (3) @(negedge sdram_clk);
      n_checks++; if (refresh_req !== 1'b1 || log_q.size() != n0) begin n_fail++; $display("FAIL refresh_hold req=%0b cmds=%0d want 1/%0d", refresh_req, log_q.size(), n0); end
      refresh_ack = 1'b1;
      @(negedge sdram_clk);
      refresh_ack = 1'b0;
      wait_log(n0 + 1, 20, ok);
      n_checks++; if (!ok || log_q[n0][AW] !== 1'b1) begin n_fail++; $display("FAIL refresh_resume cmds=%0d want %0d write", log_q.size(), n0 + 1); end
      n_checks++; if (refresh_req !== 1'b0) begin n_fail++; $display("FAIL refresh_clear got %0b want 0", refresh_req); end
      wr_enable = 1'b0;
      wait_idle(100, ok);
   endtask
`else
   task automatic test_refresh();
      bit ok;
      bit saw_req;
      log_q.delete();
      saw_req   = 1'b0;
      wr_enable = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge sdram_clk);
         refresh_ack = (i == 10);
         if (refresh_req) saw_req = 1'b1;
      end
      refresh_ack = 1'b0;
      wr_enable   = 1'b0;
      wait_idle(100, ok);
      n_checks++; if (saw_req !== 1'b0) begin n_fail++; $display("FAIL norefresh_req got 1 want 0"); end
      n_checks++; if (log_q.size() < 6 || used_blocks !== 4'(2 + log_q.size())) begin n_fail++; $display("FAIL norefresh_progress cmds=%0d used=%0d want >=6 and used=2+cmds", log_q.size(), used_blocks); end
   endtask
`endif

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      bfm_en        = 1'b0;
      bfm_same      = 1'b0;
      sdram_rst     = 1'b1;
      wr_enable     = 1'b0;
      rd_enable     = 1'b0;
      in_fifo_count = 16'd0;
      out_fifo_free = 16'd0;
      cmd_ack       = 1'b0;
      cmd_done      = 1'b0;
      refresh_ack   = 1'b0;
      fork
         bfm();
      join_none
      test_reset();
      test_write_fill();
      test_read_drain();
      test_alternate();
      test_reset_mid();
      test_ack_done_same_cycle();
      test_refresh();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
